// File: rtl/compute_job_dispatcher.sv
// rtl/compute_job_dispatcher.sv - queued matrix-job launcher with BRAM read arbitration, job timing, watchdog and abort
module compute_job_dispatcher #(
    parameter int          ADDR_WIDTH     = 14,
    parameter int          QUEUE_DEPTH    = 4,
    parameter int          OP_WIDTH       = 3,
    parameter int          ID_WIDTH       = 3,
    parameter int          SCALAR_WIDTH   = 32,
    parameter int          CNT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               abort,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [OP_WIDTH-1:0]                req_op,
    input  logic [ID_WIDTH-1:0]                req_matrix_a,
    input  logic [ID_WIDTH-1:0]                req_matrix_b,
    input  logic [SCALAR_WIDTH-1:0]            req_scalar,
    output logic                               exe_start,
    output logic [OP_WIDTH-1:0]                exe_op,
    output logic [ID_WIDTH-1:0]                exe_matrix_a,
    output logic [ID_WIDTH-1:0]                exe_matrix_b,
    output logic [SCALAR_WIDTH-1:0]            exe_scalar,
    input  logic                               exe_done,
    input  logic [ADDR_WIDTH-1:0]              sel_bram_addr,
    input  logic [ADDR_WIDTH-1:0]              exe_bram_addr,
    output logic [ADDR_WIDTH-1:0]              bram_rd_addr,
    output logic                               busy,
    output logic                               job_done,
    output logic                               job_timeout,
    output logic                               job_aborted,
    output logic [CNT_WIDTH-1:0]               last_cycles,
    output logic [OP_WIDTH-1:0]                last_op,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
    output logic [15:0]                        jobs_completed
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int EW = OP_WIDTH + 2 * ID_WIDTH + SCALAR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [EW-1:0]          fifo_mem [QUEUE_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CNT_WIDTH-1:0]   cycle_cnt;
    logic [CNT_WIDTH-1:0]   cycle_inc;
    logic                   push;
    logic                   pop;
    logic                   done_hit;
    logic                   wdog_hit;

    // Acceptance looks only at the registered count, so a same-cycle pop never frees a slot.
    assign req_ready = (queue_count < CW'(QUEUE_DEPTH)) && !abort;
    assign push      = req_valid && req_ready;
    assign pop       = (state == S_IDLE) && (queue_count != '0) && !abort;
    assign cycle_inc = cycle_cnt + CNT_WIDTH'(1);
    assign done_hit  = (state == S_RUN) && exe_done && !abort;
    assign wdog_hit  = (TIMEOUT_CYCLES != 0) && (state == S_RUN) && !exe_done && !abort
                       && (cycle_inc == TIMEOUT_VAL);

    assign exe_start    = (state == S_LAUNCH);
    assign bram_rd_addr = (state == S_IDLE) ? sel_bram_addr : exe_bram_addr;
    assign busy         = (state != S_IDLE) || (queue_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (queue_count != '0) state_nxt = S_LAUNCH;
                S_LAUNCH: state_nxt = S_RUN;
                S_RUN:    if (done_hit || wdog_hit) state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_op, req_matrix_a, req_matrix_b, req_scalar};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= '0;
        end else if (abort) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            queue_count <= queue_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_op         <= '0;
            exe_matrix_a   <= '0;
            exe_matrix_b   <= '0;
            exe_scalar     <= '0;
            cycle_cnt      <= '0;
            last_cycles    <= '0;
            last_op        <= '0;
            jobs_completed <= '0;
            job_done       <= 1'b0;
            job_timeout    <= 1'b0;
            job_aborted    <= 1'b0;
        end else begin
            job_done    <= done_hit;
            job_timeout <= wdog_hit;
            job_aborted <= abort && (state != S_IDLE);

            if (abort || state == S_LAUNCH) begin
                cycle_cnt <= '0;
            end else if (state == S_RUN) begin
                cycle_cnt <= cycle_inc;
            end

            if (pop) begin
                {exe_op, exe_matrix_a, exe_matrix_b, exe_scalar} <= fifo_mem[rd_ptr];
            end

            // Done outranks a watchdog expiry landing in the same cycle.
            if (done_hit) begin
                last_cycles <= cycle_inc;
                last_op     <= exe_op;
                if (jobs_completed != 16'hFFFF) begin
                    jobs_completed <= jobs_completed + 16'd1;
                end
            end else if (wdog_hit) begin
                last_cycles <= TIMEOUT_VAL;
                last_op     <= exe_op;
            end
        end
    end

endmodule

// File: tb/tb_compute_job_dispatcher.sv
// tb/tb_compute_job_dispatcher.sv - scoreboard bench for compute_job_dispatcher
module tb_compute_job_dispatcher;

    localparam int AW   = 14;
    localparam int QD   = 4;
    localparam int OPW  = 3;
    localparam int IDW  = 3;
    localparam int SW   = 32;
    localparam int CNTW = 32;
    localparam int TO   = 16;
    localparam int NEVER = 1 << 30;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             abort = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [OPW-1:0]   req_op = '0;
    logic [IDW-1:0]   req_matrix_a = '0;
    logic [IDW-1:0]   req_matrix_b = '0;
    logic [SW-1:0]    req_scalar = '0;
    logic             exe_start;
    logic [OPW-1:0]   exe_op;
    logic [IDW-1:0]   exe_matrix_a;
    logic [IDW-1:0]   exe_matrix_b;
    logic [SW-1:0]    exe_scalar;
    logic             exe_done = 1'b0;
    logic [AW-1:0]    sel_bram_addr = 14'h0123;
    logic [AW-1:0]    exe_bram_addr = 14'h2ABC;
    logic [AW-1:0]    bram_rd_addr;
    logic             busy;
    logic             job_done;
    logic             job_timeout;
    logic             job_aborted;
    logic [CNTW-1:0]  last_cycles;
    logic [OPW-1:0]   last_op;
    logic [2:0]       queue_count;
    logic [15:0]      jobs_completed;

    compute_job_dispatcher #(
        .ADDR_WIDTH(AW), .QUEUE_DEPTH(QD), .OP_WIDTH(OPW), .ID_WIDTH(IDW),
        .SCALAR_WIDTH(SW), .CNT_WIDTH(CNTW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_matrix_a(req_matrix_a), .req_matrix_b(req_matrix_b), .req_scalar(req_scalar),
        .exe_start(exe_start), .exe_op(exe_op), .exe_matrix_a(exe_matrix_a),
        .exe_matrix_b(exe_matrix_b), .exe_scalar(exe_scalar), .exe_done(exe_done),
        .sel_bram_addr(sel_bram_addr), .exe_bram_addr(exe_bram_addr),
        .bram_rd_addr(bram_rd_addr), .busy(busy), .job_done(job_done),
        .job_timeout(job_timeout), .job_aborted(job_aborted),
        .last_cycles(last_cycles), .last_op(last_op),
        .queue_count(queue_count), .jobs_completed(jobs_completed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OPW-1:0] op;
        logic [IDW-1:0] a;
        logic [IDW-1:0] b;
        logic [SW-1:0]  s;
    } job_t;

    typedef struct {
        bit             is_done;
        int             cycles;
        logic [OPW-1:0] op;
    } res_t;

    job_t exp_launch[$];
    res_t exp_res[$];
    job_t cur_job;
    job_t mj;
    res_t mr;
    int   md;
    bit   in_job = 0;
    bit   exp_abort_pulse = 0;
    int   cyc = 0;
    int   done_at = NEVER;
    int   ret_at = NEVER;
    int   exp_start_at = NEVER;
    int   exp_jobs = 0;
    int   exp_last_cycles = 0;
    logic [OPW-1:0] exp_last_op = '0;
    int   dur_mode = -1;
    int   accepted = 0;
    bit   noise_en = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Executor stand-in: done on the chosen RUN cycle, plus spurious pulses while no job runs.
    always @(posedge clk) begin
        #1;
        exe_done = (cyc == done_at) || (noise_en && !in_job && ($urandom_range(0, 3) == 0));
    end

    // Monitor / reference model
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_launch.delete();
            exp_res.delete();
            in_job = 0; exp_abort_pulse = 0;
            done_at = NEVER; ret_at = NEVER; exp_start_at = NEVER;
            exp_jobs = 0; exp_last_cycles = 0; exp_last_op = '0;
            chk("rst_exe_start", exe_start, 0);
            chk("rst_pulses", {job_done, job_timeout, job_aborted}, 0);
            chk("rst_busy", busy, 0);
            chk("rst_queue_count", queue_count, 0);
            chk("rst_exe_regs", {exe_op, exe_matrix_a, exe_matrix_b, exe_scalar}, 0);
            chk("rst_last", {last_op, last_cycles}, 0);
            chk("rst_jobs_completed", jobs_completed, 0);
            chk("rst_req_ready", req_ready, !abort);
            chk("rst_bram_addr", bram_rd_addr, sel_bram_addr);
        end else begin
            if (cyc == exp_start_at) chk("launch_gap", exe_start, 1);
            if (exe_start) begin
                if (exp_launch.size() == 0) begin
                    chk("unexpected_exe_start", 1, 0);
                end else begin
                    mj = exp_launch.pop_front();
                    chk("launch_operands", {exe_op, exe_matrix_a, exe_matrix_b, exe_scalar},
                        {mj.op, mj.a, mj.b, mj.s});
                    chk("launch_while_running", in_job, 0);
                    cur_job = mj;
                    in_job = 1;
                    exp_start_at = NEVER;
                    md = (dur_mode < 0) ? $urandom_range(1, 20) : dur_mode;
                    if (md <= TO) begin
                        done_at = cyc + md;
                        mr.is_done = 1; mr.cycles = md;
                    end else begin
                        done_at = NEVER;
                        mr.is_done = 0; mr.cycles = TO;
                    end
                    mr.op = mj.op;
                    exp_res.push_back(mr);
                    ret_at = cyc + mr.cycles + 1;
                end
            end

            if (cyc == ret_at && exp_res.size() != 0) begin
                mr = exp_res.pop_front();
                chk("job_done", job_done, mr.is_done);
                chk("job_timeout", job_timeout, !mr.is_done);
                exp_last_cycles = mr.cycles;
                exp_last_op = mr.op;
                if (mr.is_done && exp_jobs < 16'hFFFF) exp_jobs++;
                in_job = 0;
                ret_at = NEVER;
                done_at = NEVER;
                exp_start_at = (exp_launch.size() != 0) ? cyc + 1 : NEVER;
            end else begin
                chk("no_job_done", job_done, 0);
                chk("no_job_timeout", job_timeout, 0);
            end

            chk("job_aborted", job_aborted, exp_abort_pulse);
            chk("queue_count", queue_count, exp_launch.size());
            chk("req_ready", req_ready, (exp_launch.size() < QD) && !abort);
            chk("busy", busy, in_job || (exp_launch.size() != 0));
            chk("bram_rd_addr", bram_rd_addr, in_job ? exe_bram_addr : sel_bram_addr);
            if (in_job)
                chk("exe_operands_stable", {exe_op, exe_matrix_a, exe_matrix_b, exe_scalar},
                    {cur_job.op, cur_job.a, cur_job.b, cur_job.s});
            chk("last_cycles", last_cycles, exp_last_cycles);
            chk("last_op", last_op, exp_last_op);
            chk("jobs_completed", jobs_completed, exp_jobs);

            exp_abort_pulse = abort && in_job;
            if (abort) begin
                exp_launch.delete();
                exp_res.delete();
                in_job = 0;
                ret_at = NEVER; done_at = NEVER; exp_start_at = NEVER;
            end else if (req_valid && exp_launch.size() < QD) begin
                mj.op = req_op; mj.a = req_matrix_a; mj.b = req_matrix_b; mj.s = req_scalar;
                exp_launch.push_back(mj);
                accepted++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [OPW-1:0] op, input logic [IDW-1:0] a,
                        input logic [IDW-1:0] b, input logic [SW-1:0] s);
        int start;
        bit ok;
        start = accepted;
        ok = 0;
        req_op = op; req_matrix_a = a; req_matrix_b = b; req_scalar = s;
        req_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            if (accepted != start) begin
                ok = 1;
                break;
            end
        end
        req_valid = 1'b0;
        if (!ok) chk("send_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            step();
            if (!in_job && exp_launch.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
        repeat (3) step();
    endtask

    task automatic send_rand();
        send(OPW'($urandom), IDW'($urandom), IDW'($urandom), $urandom);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) step();

        // single job, done on the 10th RUN cycle
        dur_mode = 10;
        send(3'd2, 3'd1, 3'd3, 32'd5);
        wait_idle();

        // done coinciding with watchdog expiry, then a plain timeout
        dur_mode = TO;
        send_rand();
        wait_idle();
        dur_mode = 100;
        send_rand();
        send_rand();
        wait_idle();

        // five back-to-back requests against a stalled executor
        for (int i = 0; i < 5; i++) send(OPW'(i), IDW'(i), IDW'(7 - i), 32'(100 + i));
        wait_idle();

        // mixed random traffic with spurious done pulses and occasional abort
        dur_mode = -1;
        noise_en = 1;
        for (int i = 0; i < 400; i++) begin
            req_valid = 1'($urandom);
            req_op = OPW'($urandom); req_matrix_a = IDW'($urandom);
            req_matrix_b = IDW'($urandom); req_scalar = $urandom;
            abort = ($urandom_range(0, 39) == 0);
            sel_bram_addr = AW'($urandom); exe_bram_addr = AW'($urandom);
            step();
        end
        req_valid = 1'b0; abort = 1'b0; noise_en = 0;
        sel_bram_addr = 14'h0123; exe_bram_addr = 14'h2ABC;
        wait_idle();

        // abort during RUN with two entries queued and a request on offer
        dur_mode = 100;
        send_rand(); send_rand(); send_rand();
        for (int k = 0; k < 50; k++) begin
            if (in_job && exp_launch.size() == 2) break;
            step();
        end
        repeat (3) step();
        chk("abort_setup", {in_job, 3'(exp_launch.size())}, {1'b1, 3'd2});
        abort = 1'b1;
        req_valid = 1'b1;
        step();
        abort = 1'b0;
        req_valid = 1'b0;
        repeat (6) step();

        // reset asserted mid-RUN
        send(3'd5, 3'd2, 3'd4, 32'hDEAD_BEEF);
        for (int k = 0; k < 20; k++) begin
            if (in_job) break;
            step();
        end
        repeat (5) step();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/compute_job_dispatcher.md
# compute_job_dispatcher

Queues validated matrix-operation requests from the operation selector, then launches them one at a time on the matrix executor. It also owns BRAM read-address arbitration between selector and executor, times each job in cycles, enforces a per-job watchdog and supports a global abort. It sits between `matrix_op_selector` and `matrix_op_executor` inside the compute subsystem. It replaces the single-shot coordination FSM with a parametrised multi-job dispatcher.

## Interface
Parameters:
- `ADDR_WIDTH`, default 14: BRAM read-address width.
- `QUEUE_DEPTH`, default 4: request FIFO entries; must be a power of two, ≥2.
- `OP_WIDTH`, default 3: operation-code width (matches `calc_type_t`).
- `ID_WIDTH`, default 3: matrix-ID width.
- `SCALAR_WIDTH`, default 32: scalar operand width.
- `CNT_WIDTH`, default 32: cycle-counter width.
- `TIMEOUT_CYCLES`, default 1000000: watchdog limit in RUN cycles; 0 disables the watchdog.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `abort`  in  1  synchronous flush of the queue and of any in-flight job.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  request can be accepted.
- `req_op`  in  OP_WIDTH  operation code.
- `req_matrix_a`, `req_matrix_b`  in  ID_WIDTH each  operand matrix IDs.
- `req_scalar`  in  SCALAR_WIDTH  scalar operand.
- `exe_start`  out  1  one-cycle launch pulse to the executor.
- `exe_op`  out  OP_WIDTH  registered operands of the current job.
- `exe_matrix_a`, `exe_matrix_b`  out  ID_WIDTH each  registered operands of the current job.
- `exe_scalar`  out  SCALAR_WIDTH  registered operand of the current job.
- `exe_done`  in  1  executor completion pulse.
- `sel_bram_addr`  in  ADDR_WIDTH  selector's BRAM read address.
- `exe_bram_addr`  in  ADDR_WIDTH  executor's BRAM read address.
- `bram_rd_addr`  out  ADDR_WIDTH  arbitrated BRAM read address.
- `busy`  out  1  dispatcher not idle or queue non-empty.
- `job_done`  out  1  one-cycle pulse when a job completes normally.
- `job_timeout`  out  1  one-cycle pulse when the watchdog expires.
- `job_aborted`  out  1  one-cycle pulse when abort kills an in-flight job.
- `last_cycles`  out  CNT_WIDTH  RUN-cycle count of the last retired job.
- `last_op`  out  OP_WIDTH  operation code of the last retired job.
- `queue_count`  out  $clog2(QUEUE_DEPTH+1)  number of queued entries.
- `jobs_completed`  out  16  saturating count of normal completions.

## Operation
- Accept: `req_ready` = (`queue_count` < QUEUE_DEPTH) && !`abort`. This uses the registered count only, so a push into a full queue is refused even if a pop happens in the same cycle.
- Push and pop in the same cycle leave `queue_count` unchanged. Pointers wrap modulo QUEUE_DEPTH.
- IDLE: if the queue is non-empty, pop the head into the `exe_*` registers and go to LAUNCH.
- LAUNCH: `exe_start`=1 for exactly this cycle; clear the counter; go to RUN. An `exe_done` seen in LAUNCH or IDLE is ignored.
- RUN: the counter increments once per cycle.
  - On `exe_done`: `last_cycles` ← counter+1, `last_op` ← `exe_op`, pulse `job_done` next cycle, increment `jobs_completed` (saturates at 0xFFFF), go to IDLE.
  - Watchdog: if counter+1 == TIMEOUT_CYCLES (TIMEOUT_CYCLES ≠ 0) without `exe_done`: `last_cycles` ← TIMEOUT_CYCLES, `last_op` ← `exe_op`, pulse `job_timeout`, go to IDLE. If `exe_done` arrives in that same cycle, done wins.
- Abort has the highest priority. On an abort cycle:
  - queue is emptied (pointers and count go to 0);
  - if the state was LAUNCH or RUN, pulse `job_aborted`;
  - state goes to IDLE and the counter is cleared;
  - no `job_done` is produced, and `last_*` and `jobs_completed` are unchanged.
- `bram_rd_addr` = `exe_bram_addr` in LAUNCH/RUN, otherwise `sel_bram_addr` (combinational).
- `busy` = (state ≠ IDLE) || (`queue_count` ≠ 0).

## Timing
- Reset values:
  - state IDLE;
  - all `exe_*` outputs, `last_cycles`, `last_op`, `queue_count`, `jobs_completed` = 0;
  - all pulse outputs = 0;
  - `busy` = 0; `req_ready` = 1 (when `abort` = 0).
- Reset mid-job discards everything; no pulses are emitted.
- Launch latency: a request accepted at edge E0 produces `exe_start` high during the cycle after E1, and RUN begins at E2.
- `job_done` and `job_timeout` are registered: high for the cycle following the terminating RUN cycle, i.e. the first IDLE cycle. The next queued job pops at that same edge, so back-to-back jobs have a 2-cycle gap from `exe_done` to the next `exe_start`.
- `exe_*` operands stay stable from LAUNCH until the next pop.

## Test plan
- Single job, op=2, a=1, b=3, scalar=5, `exe_done` on the 10th RUN cycle:
  - exactly one `exe_start` with those operands;
  - `job_done` pulse; `last_cycles`=10, `last_op`=2, `jobs_completed`=1.
- Push 5 requests back-to-back with QUEUE_DEPTH=4 while the executor is stalled:
  - `req_ready` drops after 4 are queued;
  - jobs are launched in FIFO order;
  - `exe_done` to next `exe_start` is 2 cycles;
  - the fifth request is accepted once space frees.
- TIMEOUT_CYCLES=16, never assert `exe_done`:
  - `job_timeout` pulses after 16 RUN cycles; `last_cycles`=16;
  - `jobs_completed` unchanged; the next queued job launches.
- `exe_done` in the same cycle the watchdog would expire (cycle 16): `job_done`=1, `job_timeout`=0, `last_cycles`=16.
- `abort` during RUN with 2 entries queued and `req_valid` high:
  - `job_aborted` pulses; `queue_count`=0; `busy`=0 next cycle;
  - no push occurs; no further `exe_start`.
- BRAM mux: `sel_bram_addr`=0x0123, `exe_bram_addr`=0x2ABC:
  - `bram_rd_addr`=0x0123 in IDLE;
  - `bram_rd_addr`=0x2ABC in LAUNCH/RUN;
  - after reset asserted mid-RUN: 0x0123 and all outputs at reset values.
